rom_access_arbiter: RTL and testbench

//  Shares one ROM port (address in, data out, fixed read latency) between NUM_REQ requesters,
//  e.g. CPU, tile fetch and sprite fetch.

---
 rtl/rom_access_arbiter.sv | 95 +++++++++
 tb/tb_rom_access_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_access_arbiter.sv
// Round-robin arbiter sharing one fixed-latency ROM port between NUM_REQ requesters.
// One access in flight at a time; data is registered and returned with a one-cycle ack.
module rom_access_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_BITS = 11,
    parameter int DATA_BITS = 8,
    parameter int LATENCY   = 2
) (
    input  logic                          clk,
    input  logic                          nRESET,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_BITS-1:0]  req_addr,
    output logic [NUM_REQ-1:0]            ack,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rom_cs,
    output logic [ADDR_BITS-1:0]          rom_addr,
    input  logic [DATA_BITS-1:0]          rom_dout,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [NUM_REQ-1:0] ACK_ONE = 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [GW-1:0]   ptr;
    logic [GW-1:0]   win;
    int              idx;

    // Scan downward so the lowest offset from ptr+1 is the last (winning) assignment.
    always_comb begin
        win = ptr;
        idx = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (req[idx]) win = GW'(idx);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req) state_nxt = WAIT;
            WAIT:    if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            ack      <= '0;
            rd_data  <= '0;
            rom_cs   <= 1'b0;
            rom_addr <= '0;
            grant_id <= '0;
            cnt      <= '0;
            ptr      <= GW'(NUM_REQ - 1);
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant_id <= win;
                        ptr      <= win;
                        rom_addr <= req_addr[int'(win)*ADDR_BITS +: ADDR_BITS];
                        rom_cs   <= 1'b1;
                        cnt      <= CW'(LATENCY - 1);
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        rd_data <= rom_dout;
                        ack     <= ACK_ONE << grant_id;
                        rom_cs  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Directed bench for rom_access_arbiter: a LATENCY=2 instance plus a LATENCY=1 instance,
// each fed by its own ROM model with the matching read pipeline.
module tb_rom_access_arbiter;
    logic        clk = 1'b0;
    logic        nRESET;
    logic [3:0]  req, ack, req_l1, ack_l1;
    logic [43:0] req_addr, req_addr_l1;
    logic [7:0]  rd_data, rom_dout, rd_data_l1, rom_dout_l1;
    logic [10:0] rom_addr, rom_addr_l1;
    logic        rom_cs, busy, rom_cs_l1, busy_l1;
    logic [1:0]  grant_id, grant_id_l1;
    logic [7:0]  rom_mem [0:2047];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    rom_access_arbiter #(.NUM_REQ(4), .ADDR_BITS(11), .DATA_BITS(8), .LATENCY(2)) dut (
        .clk(clk), .nRESET(nRESET), .req(req), .req_addr(req_addr), .ack(ack),
        .rd_data(rd_data), .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_dout(rom_dout),
        .busy(busy), .grant_id(grant_id));

    rom_access_arbiter #(.NUM_REQ(4), .ADDR_BITS(11), .DATA_BITS(8), .LATENCY(1)) dut_l1 (
        .clk(clk), .nRESET(nRESET), .req(req_l1), .req_addr(req_addr_l1), .ack(ack_l1),
        .rd_data(rd_data_l1), .rom_cs(rom_cs_l1), .rom_addr(rom_addr_l1), .rom_dout(rom_dout_l1),
        .busy(busy_l1), .grant_id(grant_id_l1));

    // LATENCY=2 ROM: one register stage; LATENCY=1 ROM: combinational.
    always @(posedge clk) rom_dout <= rom_mem[rom_addr];
    assign rom_dout_l1 = rom_mem[rom_addr_l1];

    function automatic logic [7:0] rom_f(input logic [10:0] a);
        if (a == 11'h123) return 8'hA5;
        return a[7:0] ^ {5'b0, a[10:8]} ^ 8'h3C;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        nRESET = 1'b0;
        req = '0;
        req_l1 = '0;
        repeat (2) @(posedge clk);
        #1 nRESET = 1'b1;
    endtask

    task automatic test_reset();
        nRESET = 1'b0;
        req = '0; req_l1 = '0; req_addr = '0; req_addr_l1 = '0;
        #1;
        checks++;
        if ({ack, rd_data, rom_cs, rom_addr, busy, grant_id} !== 27'd0) begin
            errors++;
            $display("FAIL reset_outputs got ack=%b rd=%h cs=%b addr=%h busy=%b gid=%0d want all zero",
                     ack, rd_data, rom_cs, rom_addr, busy, grant_id);
        end
        repeat (2) @(posedge clk);
        #1 nRESET = 1'b1;
    endtask

    task automatic test_single();
        req_addr[10:0] = 11'h123;
        req = 4'b0001;
        tick();
        checks++;
        if (rom_addr !== 11'h123 || rom_cs !== 1'b1 || busy !== 1'b1 || grant_id !== 2'd0 || ack !== 4'b0) begin
            errors++;
            $display("FAIL single_grant got addr=%h cs=%b busy=%b gid=%0d ack=%b want 123 1 1 0 0000",
                     rom_addr, rom_cs, busy, grant_id, ack);
        end
        tick();
        checks++;
        if (ack !== 4'b0) begin errors++; $display("FAIL single_early_ack got %b want 0000", ack); end
        tick();
        checks++;
        if (ack !== 4'b0001 || rd_data !== 8'hA5 || rom_cs !== 1'b0) begin
            errors++;
            $display("FAIL single_ack got ack=%b rd=%h cs=%b want 0001 a5 0", ack, rd_data, rom_cs);
        end
        req = '0;
        tick();
        checks++;
        if (ack !== 4'b0 || busy !== 1'b0 || rd_data !== 8'hA5) begin
            errors++;
            $display("FAIL single_idle got ack=%b busy=%b rd=%h want 0000 0 a5", ack, busy, rd_data);
        end
    endtask

    task automatic test_rotation();
        logic [10:0] addrs [4];
        int nack = 0;
        int last = 0;
        addrs[0] = 11'h011; addrs[1] = 11'h122; addrs[2] = 11'h233; addrs[3] = 11'h344;
        apply_reset();
        req_addr = {addrs[3], addrs[2], addrs[1], addrs[0]};
        req = 4'b1111;
        for (int c = 1; c <= 40 && nack < 5; c++) begin
            tick();
            if (ack !== 4'b0) begin
                checks++;
                if (ack !== (4'b0001 << (nack % 4)) || rd_data !== rom_f(addrs[nack % 4])) begin
                    errors++;
                    $display("FAIL rotation_ack%0d got ack=%b rd=%h want %b %h", nack, ack, rd_data,
                             4'b0001 << (nack % 4), rom_f(addrs[nack % 4]));
                end
                checks++;
                if ((nack == 0 && c != 3) || (nack > 0 && c - last != 4)) begin
                    errors++;
                    $display("FAIL rotation_spacing%0d got cycle=%0d prev=%0d want first at 3, spacing 4", nack, c, last);
                end
                last = c;
                nack++;
            end
        end
        checks++;
        if (nack < 5) begin errors++; $display("FAIL rotation_timeout got %0d acks want 5", nack); end
        req = '0;
        repeat (2) tick();
    endtask

    task automatic test_drop();
        req_addr[32:22] = 11'h2AB;
        req = 4'b0100;
        tick();
        checks++;
        if (grant_id !== 2'd2 || rom_addr !== 11'h2AB) begin
            errors++;
            $display("FAIL drop_grant got gid=%0d addr=%h want 2 2ab", grant_id, rom_addr);
        end
        req_addr[32:22] = 11'h055;
        req = '0;
        tick();
        checks++;
        if (ack !== 4'b0 || rom_addr !== 11'h2AB) begin
            errors++;
            $display("FAIL drop_hold got ack=%b addr=%h want 0000 2ab", ack, rom_addr);
        end
        tick();
        checks++;
        if (ack !== 4'b0100 || rd_data !== rom_f(11'h2AB)) begin
            errors++;
            $display("FAIL drop_ack got ack=%b rd=%h want 0100 %h", ack, rd_data, rom_f(11'h2AB));
        end
        repeat (2) tick();
        checks++;
        if (ack !== 4'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL drop_no_regrant got ack=%b busy=%b want 0000 0", ack, busy);
        end
    endtask

    task automatic test_reset_mid();
        int spurious = 0;
        req_addr[10:0] = 11'h123;
        req = 4'b0001;
        tick();
        #2 nRESET = 1'b0;
        req = '0;
        #1;
        checks++;
        if ({ack, rd_data, rom_cs, rom_addr, busy, grant_id} !== 27'd0) begin
            errors++;
            $display("FAIL midreset_outputs got ack=%b rd=%h cs=%b addr=%h busy=%b gid=%0d want all zero",
                     ack, rd_data, rom_cs, rom_addr, busy, grant_id);
        end
        repeat (2) @(posedge clk);
        #1 nRESET = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (ack !== 4'b0 || busy !== 1'b0) spurious++;
        end
        checks++;
        if (spurious != 0) begin errors++; $display("FAIL midreset_no_ack got %0d active cycles want 0", spurious); end
        req_addr[21:11] = 11'h3C7;
        req = 4'b0010;
        tick();
        checks++;
        if (grant_id !== 2'd1 || rom_addr !== 11'h3C7) begin
            errors++;
            $display("FAIL midreset_regrant got gid=%0d addr=%h want 1 3c7", grant_id, rom_addr);
        end
        req = '0;
        repeat (2) tick();
        checks++;
        if (ack !== 4'b0010 || rd_data !== rom_f(11'h3C7)) begin
            errors++;
            $display("FAIL midreset_ack got ack=%b rd=%h want 0010 %h", ack, rd_data, rom_f(11'h3C7));
        end
        repeat (2) tick();
    endtask

    task automatic test_wrap();
        req_addr[43:33] = 11'h70F;
        req_addr[10:0]  = 11'h0F0;
        req = 4'b1000;
        repeat (3) tick();
        checks++;
        if (ack !== 4'b1000) begin errors++; $display("FAIL wrap_setup got ack=%b want 1000", ack); end
        req = 4'b1001;
        repeat (2) tick();
        checks++;
        if (grant_id !== 2'd0 || rom_addr !== 11'h0F0) begin
            errors++;
            $display("FAIL wrap_to0 got gid=%0d addr=%h want 0 0f0", grant_id, rom_addr);
        end
        repeat (2) tick();
        checks++;
        if (ack !== 4'b0001 || rd_data !== rom_f(11'h0F0)) begin
            errors++;
            $display("FAIL wrap_ack0 got ack=%b rd=%h want 0001 %h", ack, rd_data, rom_f(11'h0F0));
        end
        repeat (2) tick();
        checks++;
        if (grant_id !== 2'd3 || rom_addr !== 11'h70F) begin
            errors++;
            $display("FAIL wrap_to3 got gid=%0d addr=%h want 3 70f", grant_id, rom_addr);
        end
        req = '0;
        repeat (2) tick();
        checks++;
        if (ack !== 4'b1000 || rd_data !== rom_f(11'h70F)) begin
            errors++;
            $display("FAIL wrap_ack3 got ack=%b rd=%h want 1000 %h", ack, rd_data, rom_f(11'h70F));
        end
        repeat (2) tick();
    endtask

    task automatic test_latency1();
        req_addr_l1[32:22] = 11'h456;
        req_l1 = 4'b0100;
        tick();
        checks++;
        if (grant_id_l1 !== 2'd2 || rom_addr_l1 !== 11'h456 || ack_l1 !== 4'b0) begin
            errors++;
            $display("FAIL lat1_grant got gid=%0d addr=%h ack=%b want 2 456 0000", grant_id_l1, rom_addr_l1, ack_l1);
        end
        tick();
        checks++;
        if (ack_l1 !== 4'b0100 || rd_data_l1 !== rom_f(11'h456) || rom_cs_l1 !== 1'b0) begin
            errors++;
            $display("FAIL lat1_ack got ack=%b rd=%h cs=%b want 0100 %h 0", ack_l1, rd_data_l1, rom_cs_l1, rom_f(11'h456));
        end
        req_l1 = '0;
        tick();
        checks++;
        if (ack_l1 !== 4'b0 || busy_l1 !== 1'b0) begin
            errors++;
            $display("FAIL lat1_idle got ack=%b busy=%b want 0000 0", ack_l1, busy_l1);
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) rom_mem[i] = rom_f(11'(i));
        test_reset();
        test_single();
        test_rotation();
        test_drop();
        test_reset_mid();
        test_wrap();
        test_latency1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
